uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It is driven by the shared baud-tick generator (i_tick at OVS x baud) and adds:
- configurable data width, oversampling, parity and stop length
- start-bit glitch rejection
- a registered output holding buffer with a read handshake
- parity, framing and overrun error reporting

It sits between the pad-side serial input and the UART interface/ALU control logic.

Parameters:
DBIT, 8, data bits per frame (5..9), LSB first
OVS, 16, i_tick pulses per bit period (even, 8..32)
SB_TICK, 16, ticks spent in stop state (OVS = 1 stop, 1.5*OVS = 1.5, 2*OVS = 2)
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_bit  in  1  serial line, idle high, asynchronous to i_clk
i_tick  in  1  oversampling strobe, one i_clk wide
i_rd  in  1  consumer acknowledge; clears o_valid
o_data  out  DBIT  received word, holding register
o_valid  out  1  o_data holds an unread word
o_done_data  out  1  one-cycle pulse per completed frame
o_parity_err  out  1  parity mismatch on the word in o_data
o_frame_err  out  1  stop bit sampled low on the word in o_data
o_overrun  out  1  sticky: a frame completed while o_valid=1 and i_rd=0

Behaviour:
Reset (async on i_rst_n low, released synchronously by the register fabric):
- state = IDLE; all counters = 0
- synchroniser flops = 1
- all outputs = 0
- Reset mid-frame aborts the frame; no done pulse is issued.

Input and counters:
- i_bit passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Tick counter s width = clog2(max(OVS, SB_TICK)).
- Bit counter n width = clog2(DBIT+1).
- Counters advance only on cycles with i_tick = 1.

State machine (states IDLE, START, DATA, PAR, STOP):
- IDLE: rx_s = 0 -> START, s = 0.
- START: on tick, when s == OVS/2-1:
  - rx_s = 1 -> IDLE (glitch rejected; no flags change)
  - otherwise -> DATA, s = 0, n = 0
  - else s++.
- DATA: on tick, when s == OVS-1: sample bit, shift right into the DBIT shift register (MSB in), s = 0. If n == DBIT-1, go to PAR when PARITY != 0, else STOP; otherwise n++.
- PAR: on tick at s == OVS-1: sampled bit compared against XOR of the data bits (even) or its inverse (odd); mismatch latched internally; -> STOP, s = 0.
- STOP: on tick at s == OVS-1: sample rx_s; 0 latches the framing error internally. At s == SB_TICK-1: -> IDLE and complete the frame.

Frame completion (registered, same cycle as STOP->IDLE):
- o_done_data = 1 for one cycle
- o_data <= shift register; o_parity_err / o_frame_err <= latched flags; o_valid <= 1
- If o_valid was 1 and i_rd = 0 that cycle: o_overrun <= 1; the new data overwrites the old (newest wins).

Read handshake:
- i_rd with o_valid = 1 clears o_valid and o_overrun next cycle.
- i_rd on the completion cycle: the new word is loaded, o_valid stays 1, no overrun.
- i_rd with o_valid = 0 is ignored.

Latency: line edge to START is 2 i_clk (synchroniser) plus one clock edge. Errors do not suppress o_valid; the consumer inspects the flags.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined: each data, parity and stop sample is the 2-of-3 majority of rx_s captured on ticks s = OVS-3, OVS-2 and OVS-1; the decision is taken at OVS-1. The start-bit check uses the majority at OVS/2-3..OVS/2-1.
- Undefined: single sample at the stated tick; the vote registers are not built.

Test Plan:
1. DBIT=8, PARITY=0, OVS=16, i_tick every cycle; send 0xA5 8N1 -> one o_done_data pulse, o_data = 0xA5, o_valid = 1, all error flags 0.
2. PARITY=2: send 0x07 with parity bit 1 -> o_parity_err = 0. Repeat with parity bit 0 -> o_parity_err = 1, o_data = 0x07.
3. Hold the line low for 0x3C including the stop bit -> o_frame_err = 1, o_data = 0x3C. FSM returns to IDLE, waits for line high plus a new falling edge, and no extra frame is reported.
4. Line low for 4 ticks then high -> no o_done_data, FSM back in IDLE, o_valid unchanged.
5. Receive 0x11 and then 0x22 without i_rd -> o_overrun = 1, o_data = 0x22. Pulse i_rd -> o_valid = 0, o_overrun = 0. Separately, i_rd on the completion cycle -> o_valid stays 1, o_overrun stays 0.
6. Assert i_rst_n = 0 during DATA bit 4 -> all outputs 0 immediately; after release, a full 0x5A frame is received correctly. With RX_MAJORITY_VOTE_EN, a 1-tick glitch at each sample point of 0x5A still gives o_data = 0x5A.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width/parity/stop, start-glitch rejection, read-handshake holding buffer.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 majority sampling around each decision tick.
module uart_rx_cfg #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_bit,
  input  logic            i_tick,
  input  logic            i_rd,
  output logic [DBIT-1:0] o_data,
  output logic            o_valid,
  output logic            o_done_data,
  output logic            o_parity_err,
  output logic            o_frame_err,
  output logic            o_overrun
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT + 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] sh_q;
  logic            perr_q;
  logic            ferr_q;
  logic [2:0]      sync_q;

  logic rx_s;
  logic fall;
  logic samp;
  logic ferr_now;
  logic done_now;

  // sync_q[2] is one cycle behind rx_s, giving a falling-edge detect so a line stuck low never restarts a frame
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0]    vote_q;
  logic [SW-1:0] tgt;

  assign tgt  = (state_q == START) ? S_MID : S_END;
  assign samp = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  always_ff @(posedge i_clk) begin
    if (i_tick) begin
      if (s_q == tgt - SW'(2)) vote_q[0] <= rx_s;
      if (s_q == tgt - SW'(1)) vote_q[1] <= rx_s;
    end
  end
`else
  assign samp = rx_s;
`endif

  assign ferr_now = ferr_q | ((s_q == S_END) & ~samp);
  assign done_now = (state_q == STOP) & i_tick & (s_q == S_STOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      sync_q       <= 3'b111;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_done_data  <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], i_bit};
      o_done_data <= 1'b0;

      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (i_tick) begin
            if (s_q == S_MID) begin
              if (samp) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (s_q == S_END) begin
              sh_q <= {samp, sh_q[DBIT-1:1]};
              s_q  <= '0;
              if (n_q == N_LAST) state_q <= (PARITY != 0) ? PAR : STOP;
              else               n_q     <= n_q + NW'(1);
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        PAR: begin
          if (i_tick) begin
            if (s_q == S_END) begin
              perr_q  <= samp ^ (^sh_q) ^ ODD;
              state_q <= STOP;
              s_q     <= '0;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if ((s_q == S_END) && !samp) ferr_q <= 1'b1;
            if (s_q == S_STOP) state_q <= IDLE;
            else               s_q     <= s_q + SW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // Holding buffer: newest word always wins; overrun only when an unread word is overwritten
      if (done_now) begin
        o_data       <= sh_q;
        o_parity_err <= perr_q;
        o_frame_err  <= ferr_now;
        o_valid      <= 1'b1;
        o_done_data  <= 1'b1;
        if (o_valid && !i_rd) o_overrun <= 1'b1;
        else if (i_rd)        o_overrun <= 1'b0;
      end else if (i_rd && o_valid) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule
